// File: rtl/mem_interface.sv
// ---------------------------------------------------------------------------
// mem_interface: multi-cycle fetch/load/store unit with PC and IR.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_interface (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ir_write,
  input  logic        adr_src,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic        pc_write,
  input  logic [31:0] result,
  input  logic [31:0] write_data,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic [31:0] instr,
  output logic [31:0] read_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        stall,
  output logic        misaligned
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state;
  logic        q_fetch;
  logic        q_load;
  logic [2:0]  q_funct3;
  logic [1:0]  q_off;

  logic [31:0] eff_addr;
  logic [1:0]  off;
  logic        is_store;
  logic        acc_byte;
  logic        acc_half;
  logic        bad_align;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign eff_addr = adr_src ? result : pc;
  assign off      = eff_addr[1:0];
  assign is_store = mem_write & ~ir_write;
  assign stall    = (state == BUSY) & ~mem_ack;

  // Store sizes decode on the full funct3; load sizes ignore the sign bit.
  always_comb begin
    acc_byte = 1'b0;
    acc_half = 1'b0;
    if (!ir_write) begin
      if (is_store) begin
        acc_byte = (funct3 == 3'b000);
        acc_half = (funct3 == 3'b001);
      end else begin
        acc_byte = (funct3[1:0] == 2'b00);
        acc_half = (funct3[1:0] == 2'b01);
      end
    end
  end

  assign bad_align = acc_half ? off[0] : (!acc_byte && (off != 2'b00));

  always_comb begin
    st_wdata = write_data;
    st_wstrb = 4'b1111;
    case (funct3)
      3'b000: begin
        st_wdata = {4{write_data[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      3'b001: begin
        st_wdata = {2{write_data[15:0]}};
        st_wstrb = 4'b0011 << off;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (q_off)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = q_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (q_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= 32'h0;
      old_pc     <= 32'h0;
      instr      <= 32'h00000013;
      read_data  <= 32'h0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'b0000;
      misaligned <= 1'b0;
      q_fetch    <= 1'b0;
      q_load     <= 1'b0;
      q_funct3   <= 3'b000;
      q_off      <= 2'b00;
    end else begin
      misaligned <= 1'b0;
      if (pc_write)
        pc <= result;
      if (state == IDLE) begin
        if (start) begin
          if (bad_align) begin
            misaligned <= 1'b1;
          end else begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_addr  <= {eff_addr[31:2], 2'b00};
            mem_we    <= is_store;
            mem_wstrb <= is_store ? st_wstrb : 4'b0000;
            mem_wdata <= st_wdata;
            q_fetch   <= ir_write;
            q_load    <= ~ir_write & ~mem_write;
            q_funct3  <= funct3;
            q_off     <= off;
          end
        end
      end else if (mem_ack) begin
        state     <= IDLE;
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_wstrb <= 4'b0000;
        // old_pc captures the register value, i.e. before a same-edge pc_write.
        if (q_fetch) begin
          instr  <= mem_rdata;
          old_pc <= pc;
        end else if (q_load) begin
          read_data <= ld_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_interface.sv
// ---------------------------------------------------------------------------
// tb_mem_interface: scoreboard bench for mem_interface.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_interface;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, ir_write, adr_src, mem_write, pc_write, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] result, write_data, mem_rdata;
  logic [31:0] pc, old_pc, instr, read_data, mem_addr, mem_wdata;
  logic        mem_req, mem_we, stall, misaligned;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  mem_interface dut (
    .clk(clk), .reset(reset), .start(start), .ir_write(ir_write),
    .adr_src(adr_src), .mem_write(mem_write), .funct3(funct3),
    .pc_write(pc_write), .result(result), .write_data(write_data),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .pc(pc), .old_pc(old_pc),
    .instr(instr), .read_data(read_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .stall(stall), .misaligned(misaligned)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        fetch;
    logic        load;
    logic [31:0] val;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] pc_m = 32'h0;
  logic [31:0] rd_m = 32'h0;
  int          stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic set_pc(input logic [31:0] v);
    @(negedge clk);
    pc_write = 1'b1; result = v;
    @(negedge clk);
    pc_write = 1'b0;
    pc_m = v;
    check("set_pc", pc, pc_m);
  endtask

  task automatic drive_start(input logic irw, input logic asrc, input logic mw,
                             input logic [2:0] f3, input logic [31:0] res, input logic [31:0] wd);
    @(negedge clk);
    start = 1'b1; ir_write = irw; adr_src = asrc; mem_write = mw;
    funct3 = f3; result = res; write_data = wd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic access(input logic irw, input logic asrc, input logic mw,
                        input logic [2:0] f3, input logic [31:0] res, input logic [31:0] wd,
                        input logic [31:0] rd, input int lat, output int n_stall);
    exp_t        e;
    logic [31:0] eff;
    logic [1:0]  o;
    logic [7:0]  b;
    logic [15:0] h;
    int          ofs;
    int          t;
    eff     = asrc ? res : pc_m;
    o       = eff[1:0];
    ofs     = 8 * int'(o);
    e.addr  = {eff[31:2], 2'b00};
    e.fetch = irw;
    e.load  = !irw && !mw;
    e.we    = mw && !irw;
    e.wstrb = 4'b0000;
    e.wdata = wd;
    if (e.we) begin
      case (f3)
        3'b000:  begin e.wdata = {4{wd[7:0]}};  e.wstrb = 4'b0001 << o; end
        3'b001:  begin e.wdata = {2{wd[15:0]}}; e.wstrb = 4'b0011 << o; end
        default: e.wstrb = 4'b1111;
      endcase
    end
    b = rd[ofs +: 8];
    h = o[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  e.val = {{24{b[7]}}, b};
      3'b100:  e.val = {24'h0, b};
      3'b001:  e.val = {{16{h[15]}}, h};
      3'b101:  e.val = {16'h0, h};
      default: e.val = rd;
    endcase
    if (irw) e.val = rd;
    sb_q.push_back(e);

    drive_start(irw, asrc, mw, f3, res, wd);
    t = 0;
    while (!mem_req && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("req_seen", {31'h0, mem_req}, 32'h1);
    e = sb_q.pop_front();
    n_stall = 0;
    if (!mem_req) return;
    check("mem_addr", mem_addr, e.addr);
    check("mem_we", {31'h0, mem_we}, {31'h0, e.we});
    check("mem_wstrb", {28'h0, mem_wstrb}, {28'h0, e.wstrb});
    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
    repeat (lat) begin
      if (stall) n_stall++;
      @(negedge clk);
    end
    mem_ack = 1'b1; mem_rdata = rd;
    #1;
    check("stall_on_ack", {31'h0, stall}, 32'h0);
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("req_drop", {31'h0, mem_req}, 32'h0);
    if (e.fetch) begin
      check("instr", instr, e.val);
      check("old_pc", old_pc, pc_m);
      check("rdata_hold_fetch", read_data, rd_m);
    end else if (e.load) begin
      rd_m = e.val;
      check("read_data", read_data, rd_m);
    end else begin
      check("rdata_hold_store", read_data, rd_m);
    end
  endtask

  task automatic misalign(input logic irw, input logic asrc, input logic mw,
                          input logic [2:0] f3, input logic [31:0] res);
    drive_start(irw, asrc, mw, f3, res, 32'hFFFF_FFFF);
    check("mis_pulse", {31'h0, misaligned}, 32'h1);
    check("mis_noreq", {31'h0, mem_req}, 32'h0);
    check("mis_nostall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    check("mis_clear", {31'h0, misaligned}, 32'h0);
    check("mis_idle", {31'h0, mem_req}, 32'h0);
    check("mis_pc", pc, pc_m);
    check("mis_rdata", read_data, rd_m);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ir_write = 1'b0; adr_src = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; pc_write = 1'b0; result = 32'h0; write_data = 32'h0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_old_pc", old_pc, 32'h0);
    check("rst_instr", instr, 32'h00000013);
    check("rst_rdata", read_data, 32'h0);
    check("rst_req", {31'h0, mem_req}, 32'h0);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_mis", {31'h0, misaligned}, 32'h0);
    reset = 1'b0;

    set_pc(32'h100);
    access(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h00500093, 3, stalls);
    check("fetch_stalls", stalls, 3);
    check("fetch_instr_lit", instr, 32'h00500093);
    check("fetch_oldpc_lit", old_pc, 32'h100);

    access(1'b0, 1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h80FFFFFF, 1, stalls);
    check("lb_lit", read_data, 32'hFFFFFF80);
    access(1'b0, 1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 32'h80FFFFFF, 2, stalls);
    check("lbu_lit", read_data, 32'h00000080);
    access(1'b0, 1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'h80011234, 1, stalls);
    check("lh_lit", read_data, 32'hFFFF8001);
    access(1'b0, 1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'h80011234, 0, stalls);
    check("lhu_lit", read_data, 32'h00008001);
    access(1'b0, 1'b1, 1'b0, 3'b000, 32'h201, 32'h0, 32'h00007F00, 0, stalls);
    check("lb_pos_lit", read_data, 32'h0000007F);
    access(1'b0, 1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'hCAFEF00D, 0, stalls);
    access(1'b0, 1'b1, 1'b1, 3'b001, 32'h302, 32'h0000BEEF, 32'h0, 1, stalls);
    access(1'b0, 1'b1, 1'b1, 3'b000, 32'h301, 32'h12345678, 32'h0, 1, stalls);
    access(1'b0, 1'b1, 1'b1, 3'b010, 32'h400, 32'hA5A5A5A5, 32'h0, 2, stalls);
    access(1'b0, 1'b1, 1'b1, 3'b111, 32'h408, 32'h01020304, 32'h0, 0, stalls);

    misalign(1'b0, 1'b1, 1'b0, 3'b010, 32'h401);
    misalign(1'b0, 1'b1, 1'b1, 3'b001, 32'h303);
    misalign(1'b0, 1'b1, 1'b0, 3'b101, 32'h201);
    misalign(1'b1, 1'b1, 1'b0, 3'b000, 32'h102);

    // Start and pc_write while busy, then pc_write on the ack edge.
    drive_start(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    check("busy_req", {31'h0, mem_req}, 32'h1);
    start = 1'b1; adr_src = 1'b1; result = 32'h500; pc_write = 1'b1;
    @(negedge clk);
    start = 1'b0; pc_write = 1'b0;
    check("busy_pc", pc, 32'h500);
    check("busy_addr", mem_addr, 32'h100);
    check("busy_req_hold", {31'h0, mem_req}, 32'h1);
    mem_ack = 1'b1; mem_rdata = 32'h00A00113; pc_write = 1'b1; result = 32'h600;
    @(negedge clk);
    mem_ack = 1'b0; pc_write = 1'b0;
    check("busy_instr", instr, 32'h00A00113);
    check("same_edge_oldpc", old_pc, 32'h500);
    check("same_edge_pc", pc, 32'h600);
    @(negedge clk);
    check("no_queue_req", {31'h0, mem_req}, 32'h0);
    check("no_queue_mis", {31'h0, misaligned}, 32'h0);
    pc_m = 32'h600;

    // Reset in the middle of an access, then a stale ack.
    drive_start(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    check("pre_rst_req", {31'h0, mem_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("arst_req", {31'h0, mem_req}, 32'h0);
    check("arst_stall", {31'h0, stall}, 32'h0);
    check("arst_instr", instr, 32'h00000013);
    check("arst_pc", pc, 32'h0);
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_instr", instr, 32'h00000013);
    check("late_ack_oldpc", old_pc, 32'h0);
    check("late_ack_req", {31'h0, mem_req}, 32'h0);
    check("late_ack_rdata", read_data, 32'h0);
    pc_m = 32'h0; rd_m = 32'h0;

    access(1'b1, 1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h00000073, 1, stalls);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL: start  in  1  one-cycle pulse requesting a memory access.
REQ-004 SHALL: ir_write  in  1  access is an instruction fetch (sampled with start).
REQ-005 SHALL: adr_src  in  1  address select: 0 = pc, 1 = result (sampled with start).
REQ-006 SHALL: mem_write  in  1  access is a store (sampled with start; ignored when ir_write=1).
REQ-007 SHALL: funct3  in  3  load/store size and sign code (sampled with start).
REQ-008 SHALL: pc_write  in  1  load pc from result.
REQ-009 SHALL: result  in  32  result bus: next PC or data address.
REQ-010 SHALL: write_data  in  32  store data (rs2 value).
REQ-011 SHALL: mem_ack  in  1  memory completion strobe.
REQ-012 SHALL: mem_rdata  in  32  memory read word, valid with mem_ack.
REQ-013 SHALL: pc, old_pc, instr, read_data  out  32 each  PC, PC of current instruction, instruction register, extended load data.
REQ-014 SHALL: mem_req, mem_we  out  1 each  request and write-enable to memory.
REQ-015 SHALL: mem_addr, mem_wdata  out  32 each  word-aligned address and lane-replicated store data.
REQ-016 SHALL: mem_wstrb  out  4  byte-lane write strobes.
REQ-017 SHALL: stall  out  1  access in progress; control must hold.
REQ-018 SHALL: misaligned  out  1  one-cycle fault pulse.

Function
REQ-019 SHALL: two-state FSM IDLE/BUSY; start in IDLE with an aligned address -> BUSY next edge.
REQ-020 SHALL: on accept, latch eff_addr = adr_src ? result : pc, plus ir_write, mem_write, funct3; drive mem_addr = {eff_addr[31:2],2'b00}.
REQ-021 SHALL: mem_req=1 exactly while BUSY; mem_addr, mem_we, mem_wdata, mem_wstrb stable from accept until the ack edge.
REQ-022 SHALL: stall = BUSY & ~mem_ack (combinational); stall=0 in IDLE.
REQ-023 SHALL: BUSY + mem_ack -> IDLE at that edge; minimum latency start-to-data = 2 edges.
REQ-024 SHALL: start while BUSY is ignored: no queueing, no fault.
REQ-025 SHALL: fetch (ir_write=1) is always a word read; on ack instr <= mem_rdata and old_pc <= pc.
REQ-026 SHALL: load funct3: 000 LB and 100 LBU select byte eff_addr[1:0]; 001 LH and 101 LHU select the half at eff_addr[1]; 010 LW takes the full word.
REQ-027 SHALL: LB/LH sign-extend, LBU/LHU zero-extend; read_data updates only on a load ack.
REQ-028 SHALL: store SB: mem_wdata = {4{wd[7:0]}}, wstrb = 4'b0001 << off.
REQ-029 SHALL: store SH: mem_wdata = {2{wd[15:0]}}, wstrb = 4'b0011 << off.
REQ-030 SHALL: store SW and every other funct3: mem_wdata = wd, wstrb = 4'b1111.
REQ-031 SHALL: mem_we=0 and wstrb=0 for reads.
REQ-032 SHALL: misalignment is a half access with off[0]=1, or a word access or fetch with off!=0.
REQ-033 SHALL: on misalignment, misaligned=1 for one cycle, no request is issued, FSM stays IDLE, and no register changes.
REQ-034 SHALL: pc <= result on any edge with pc_write=1, including while BUSY; an in-flight address is unaffected.
REQ-035 SHALL: when pc_write and a fetch ack share an edge, old_pc receives the pre-update pc.

Reset
REQ-036 SHALL: asynchronous reset forces IDLE, pc=0, old_pc=0, instr=32'h00000013, read_data=0, mem_req=0, mem_we=0, mem_wstrb=0, stall=0, misaligned=0.
REQ-037 SHALL: reset mid-access abandons the access; a late mem_ack after reset release is ignored while IDLE.

Verification
REQ-038 SHALL: fetch, pc=0x100, mem_rdata=0x00500093 with ack 3 cycles later -> instr=0x00500093, old_pc=0x100, stall high for 3 cycles.
REQ-039 SHALL: LB at result=0x203, rdata=0x80FFFFFF -> read_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-040 SHALL: SH at 0x302, wd=0x0000BEEF -> mem_addr=0x300, wstrb=4'b1100, mem_wdata=0xBEEFBEEF, mem_we=1.
REQ-041 SHALL: LW at 0x401 -> misaligned pulse, mem_req stays 0, state IDLE.
REQ-042 SHALL: second start during BUSY and pc_write (result=0x500) during BUSY -> single request with the original address, pc=0x500.
REQ-043 SHALL: reset asserted in BUSY -> mem_req=0 immediately, instr=0x00000013, and a later ack has no effect.
